// File: rtl/lcd_img_proc_ctrl.sv
// Image-buffer controller: loads IMG_W x IMG_W pixels from IROM, runs 2x2-window commands, streams result to IRAM.
// Optional feature macro: LCD_IMG_INVERT_EN (cmd C inverts the window pixels).
module lcd_img_proc_ctrl #(
    parameter int IMG_W  = 8,
    parameter int DATA_W = 8,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [3:0]        cmd,
    input  logic              cmd_valid,
    output logic              busy,
    output logic              irom_rd,
    output logic [ADDR_W-1:0] irom_a,
    input  logic [DATA_W-1:0] irom_q,
    output logic              iram_valid,
    output logic [ADDR_W-1:0] iram_a,
    output logic [DATA_W-1:0] iram_d,
    output logic              done
);
    localparam int N  = IMG_W * IMG_W;
    localparam int CW = ADDR_W / 2;
    localparam logic [ADDR_W:0]   LD_END = (ADDR_W+1)'(N);
    localparam logic [ADDR_W-1:0] WR_END = ADDR_W'(N - 1);
    localparam logic [CW-1:0]     P_MIN  = CW'(1);
    localparam logic [CW-1:0]     P_MAX  = CW'(IMG_W - 1);

    typedef enum logic [2:0] {S_LOAD, S_IDLE, S_EXEC, S_WRITE, S_DONE} state_t;

    state_t              state, state_nx;
    logic [ADDR_W:0]     ld_cnt;
    logic [ADDR_W-1:0]   ld_idx;
    logic [ADDR_W-1:0]   wr_cnt;
    logic [CW-1:0]       px, py, xm1, ym1;
    logic [3:0]          cmd_q;
    logic [DATA_W-1:0]   pix [N];
    logic                accept;

    logic [ADDR_W-1:0]   i_tl, i_tr, i_bl, i_br;
    logic [DATA_W-1:0]   w_tl, w_tr, w_bl, w_br;
    logic [DATA_W-1:0]   n_tl, n_tr, n_bl, n_br;
    logic [DATA_W-1:0]   hi_t, hi_b, lo_t, lo_b, w_max, w_min, w_avg;
    logic [DATA_W+1:0]   w_sum;
    logic                upd;

    assign busy       = !(state == S_IDLE || state == S_DONE);
    assign accept     = cmd_valid && !busy;
    assign irom_rd    = (state == S_LOAD);
    assign irom_a     = ld_cnt[ADDR_W-1:0];
    assign iram_valid = (state == S_WRITE);
    assign iram_a     = iram_valid ? wr_cnt : '0;
    assign iram_d     = iram_valid ? pix[wr_cnt] : '0;
    assign done       = (state == S_DONE);

    // Data for address k arrives one cycle late, so the capture slot trails the counter by one.
    assign ld_idx = ld_cnt[ADDR_W-1:0] - 1'b1;

    // Power-of-two side lets the window index be a plain {row, col} concatenation.
    assign xm1  = px - P_MIN;
    assign ym1  = py - P_MIN;
    assign i_tl = {ym1, xm1};
    assign i_tr = {ym1, px};
    assign i_bl = {py, xm1};
    assign i_br = {py, px};
    assign w_tl = pix[i_tl];
    assign w_tr = pix[i_tr];
    assign w_bl = pix[i_bl];
    assign w_br = pix[i_br];

    assign hi_t  = (w_tl > w_tr) ? w_tl : w_tr;
    assign hi_b  = (w_bl > w_br) ? w_bl : w_br;
    assign lo_t  = (w_tl < w_tr) ? w_tl : w_tr;
    assign lo_b  = (w_bl < w_br) ? w_bl : w_br;
    assign w_max = (hi_t > hi_b) ? hi_t : hi_b;
    assign w_min = (lo_t < lo_b) ? lo_t : lo_b;
    assign w_sum = {2'b00, w_tl} + {2'b00, w_tr} + {2'b00, w_bl} + {2'b00, w_br};
    assign w_avg = DATA_W'(w_sum >> 2);

    always_comb begin
        n_tl = w_tl;
        n_tr = w_tr;
        n_bl = w_bl;
        n_br = w_br;
        upd  = 1'b1;
        case (cmd_q)
            4'h5: begin n_tl = w_max; n_tr = w_max; n_bl = w_max; n_br = w_max; end
            4'h6: begin n_tl = w_min; n_tr = w_min; n_bl = w_min; n_br = w_min; end
            4'h7: begin n_tl = w_avg; n_tr = w_avg; n_bl = w_avg; n_br = w_avg; end
            4'h8: begin n_tl = w_tr;  n_tr = w_br;  n_br = w_bl;  n_bl = w_tl;  end
            4'h9: begin n_tl = w_bl;  n_bl = w_br;  n_br = w_tr;  n_tr = w_tl;  end
            4'hA: begin n_tl = w_bl;  n_bl = w_tl;  n_tr = w_br;  n_br = w_tr;  end
            4'hB: begin n_tl = w_tr;  n_tr = w_tl;  n_bl = w_br;  n_br = w_bl;  end
`ifdef LCD_IMG_INVERT_EN
            4'hC: begin n_tl = ~w_tl; n_tr = ~w_tr; n_bl = ~w_bl; n_br = ~w_br; end
`endif
            default: upd = 1'b0;
        endcase
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_LOAD:  if (ld_cnt == LD_END) state_nx = S_IDLE;
            S_EXEC:  state_nx = S_IDLE;
            S_WRITE: if (wr_cnt == WR_END) state_nx = S_DONE;
            S_IDLE, S_DONE: begin
                state_nx = S_IDLE;
                if (accept) state_nx = (cmd == 4'h0) ? S_WRITE : S_EXEC;
            end
            default: state_nx = S_LOAD;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_LOAD;
        else       state <= state_nx;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ld_cnt <= '0;
            wr_cnt <= '0;
            px     <= CW'(IMG_W / 2);
            py     <= CW'(IMG_W / 2);
            cmd_q  <= '0;
        end else begin
            if (state == S_LOAD && ld_cnt != LD_END) ld_cnt <= ld_cnt + 1'b1;
            if (accept) begin
                cmd_q  <= cmd;
                wr_cnt <= '0;
            end
            if (state == S_WRITE) wr_cnt <= wr_cnt + 1'b1;
            if (state == S_EXEC) begin
                case (cmd_q)
                    4'h1: if (py != P_MIN) py <= py - 1'b1;
                    4'h2: if (py != P_MAX) py <= py + 1'b1;
                    4'h3: if (px != P_MIN) px <= px - 1'b1;
                    4'h4: if (px != P_MAX) px <= px + 1'b1;
                    default: ;
                endcase
            end
        end
    end

    // Pixel store has no reset; a reset restarts the load, which overwrites every entry.
    always_ff @(posedge clk) begin
        if (state == S_LOAD && ld_cnt != '0) begin
            pix[ld_idx] <= irom_q;
        end else if (state == S_EXEC && upd) begin
            pix[i_tl] <= n_tl;
            pix[i_tr] <= n_tr;
            pix[i_bl] <= n_bl;
            pix[i_br] <= n_br;
        end
    end
endmodule

// File: tb/tb_lcd_img_proc_ctrl.sv
// Bench for lcd_img_proc_ctrl: directed and random command streams checked against an array-level image model.
module tb_lcd_img_proc_ctrl;
    localparam int IMG_W  = 8;
    localparam int DATA_W = 8;
    localparam int ADDR_W = 6;
    localparam int N      = IMG_W * IMG_W;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [3:0]        cmd = 4'h0;
    logic              cmd_valid = 1'b0;
    logic              busy, irom_rd, iram_valid, done;
    logic [ADDR_W-1:0] irom_a, iram_a;
    logic [DATA_W-1:0] irom_q = '0;
    logic [DATA_W-1:0] iram_d;

    int checks = 0, failures = 0;
    int rom [N];
    int img [N];
    int ram [N];
    int mx, my;

    lcd_img_proc_ctrl #(.IMG_W(IMG_W), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .reset(reset), .cmd(cmd), .cmd_valid(cmd_valid), .busy(busy),
        .irom_rd(irom_rd), .irom_a(irom_a), .irom_q(irom_q),
        .iram_valid(iram_valid), .iram_a(iram_a), .iram_d(iram_d), .done(done)
    );

    always #5 clk = ~clk;

    // Synchronous IROM: data for the presented address appears the next cycle.
    always @(posedge clk) irom_q <= 8'(rom[irom_a]);

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic int pidx(input int r, input int c);
        return r * IMG_W + c;
    endfunction

    task automatic model(input int c);
        int a, b, d, e, ta, tb, td, te, s;
        a = pidx(my - 1, mx - 1); b = pidx(my - 1, mx);
        d = pidx(my, mx - 1);     e = pidx(my, mx);
        ta = img[a]; tb = img[b]; td = img[d]; te = img[e];
        case (c)
            1: if (my > 1) my--;
            2: if (my < IMG_W - 1) my++;
            3: if (mx > 1) mx--;
            4: if (mx < IMG_W - 1) mx++;
            5: begin
                s = ta;
                if (tb > s) s = tb;
                if (td > s) s = td;
                if (te > s) s = te;
                img[a] = s; img[b] = s; img[d] = s; img[e] = s;
            end
            6: begin
                s = ta;
                if (tb < s) s = tb;
                if (td < s) s = td;
                if (te < s) s = te;
                img[a] = s; img[b] = s; img[d] = s; img[e] = s;
            end
            7: begin
                s = (ta + tb + td + te) / 4;
                img[a] = s; img[b] = s; img[d] = s; img[e] = s;
            end
            8:  begin img[a] = tb; img[b] = te; img[e] = td; img[d] = ta; end
            9:  begin img[a] = td; img[d] = te; img[e] = tb; img[b] = ta; end
            10: begin img[a] = td; img[d] = ta; img[b] = te; img[e] = tb; end
            11: begin img[a] = tb; img[b] = ta; img[d] = te; img[e] = td; end
`ifdef LCD_IMG_INVERT_EN
            12: begin img[a] = 255 - ta; img[b] = 255 - tb; img[d] = 255 - td; img[e] = 255 - te; end
`endif
            default: ;
        endcase
    endtask

    // Reset is already high on entry; release it and time the load.
    task automatic load_wait(input bit hold);
        int n, bad;
        for (int k = 0; k < N; k++) img[k] = rom[k];
        mx = IMG_W / 2; my = IMG_W / 2;
        if (hold) begin cmd = 4'h5; cmd_valid = 1'b1; end
        @(negedge clk);
        reset = 1'b0;
        n = 0; bad = 0;
        do begin
            @(negedge clk);
            n++;
            if (n < N && int'(irom_a) != n) bad++;
            if (hold && n == N - 4) cmd_valid = 1'b0;
        end while (busy && n < 200);
        chk("load_cyc", n, N + 1);
        chk("irom_a_seq", bad, 0);
        chk("irom_rd_off", irom_rd, 0);
    endtask

    task automatic do_reset(input bit hold);
        @(negedge clk);
        reset = 1'b1; cmd_valid = 1'b0;
        @(negedge clk);
        chk("rst_busy", busy, 1);
        chk("rst_irom_rd", irom_rd, 1);
        chk("rst_irom_a", irom_a, 0);
        chk("rst_iram_valid", iram_valid, 0);
        chk("rst_iram_a", iram_a, 0);
        chk("rst_iram_d", iram_d, 0);
        chk("rst_done", done, 0);
        load_wait(hold);
    endtask

    task automatic send(input int c);
        @(negedge clk);
        cmd = 4'(c); cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("busy_exec", busy, 1);
        @(negedge clk);
        chk("busy_rel", busy, 0);
        model(c);
    endtask

    task automatic do_write(input bit hold);
        int bad, mism;
        bit got_done;
        for (int k = 0; k < N; k++) ram[k] = -1;
        @(negedge clk);
        cmd = 4'h0; cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = hold;
        if (hold) cmd = 4'h5;
        bad = 0; got_done = 1'b0;
        for (int cyc = 0; cyc < N + 10 && !got_done; cyc++) begin
            if (cyc > 0) @(negedge clk);
            if (hold && cyc == N - 4) cmd_valid = 1'b0;
            if (cyc < N) begin
                if (!iram_valid || int'(iram_a) != cyc) bad++;
                else ram[cyc] = int'(iram_d);
            end else if (iram_valid) bad++;
            if (done) begin
                got_done = 1'b1;
                chk("done_cyc", cyc, N);
                chk("done_busy", busy, 0);
            end
        end
        chk("wr_seq", bad, 0);
        chk("wr_done", got_done, 1);
        @(negedge clk);
        chk("done_pulse", done, 0);
        mism = 0;
        for (int k = 0; k < N; k++) if (ram[k] != img[k]) mism++;
        chk("img", mism, 0);
    endtask

    task automatic write_abort(input int at);
        @(negedge clk);
        cmd = 4'h0; cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (at) @(negedge clk);
        chk("abort_pre_valid", iram_valid, 1);
        chk("abort_pre_a", iram_a, at);
        reset = 1'b1;
        #1;
        chk("abort_valid", iram_valid, 0);
        chk("abort_busy", busy, 1);
        chk("abort_irom_rd", irom_rd, 1);
        chk("abort_irom_a", irom_a, 0);
        @(negedge clk);
        load_wait(1'b0);
    endtask

    initial begin
        for (int k = 0; k < N; k++) rom[k] = k;

        do_reset(1'b0);
        do_write(1'b0);

        send(7);
        do_write(1'b0);
        chk("avg_27", ram[27], 31);
        chk("avg_28", ram[28], 31);
        chk("avg_35", ram[35], 31);
        chk("avg_36", ram[36], 31);

        do_reset(1'b0);
        send(9);
        do_write(1'b0);
        chk("cw_27", ram[27], 35);
        chk("cw_28", ram[28], 27);
        chk("cw_35", ram[35], 36);
        chk("cw_36", ram[36], 28);
        send(8);
        do_write(1'b0);
        chk("ccw_27", ram[27], 27);
        chk("ccw_28", ram[28], 28);
        chk("ccw_35", ram[35], 35);
        chk("ccw_36", ram[36], 36);

        do_reset(1'b0);
        repeat (5) send(1);
        repeat (6) send(3);
        send(5);
        do_write(1'b0);
        chk("sat_max_0", ram[0], 9);
        chk("sat_max_1", ram[1], 9);
        chk("sat_max_8", ram[8], 9);
        chk("sat_max_9", ram[9], 9);
        repeat (8) send(4);
        repeat (8) send(2);
        send(10);
        send(7);
        do_write(1'b0);

        do_reset(1'b1);
        do_write(1'b1);

        send(4);
        send(1);
        write_abort(20);
        send(7);
        do_write(1'b0);
        chk("rst_pt_27", ram[27], 31);
        chk("rst_pt_36", ram[36], 31);

`ifdef LCD_IMG_INVERT_EN
        do_reset(1'b0);
        send(12);
        do_write(1'b0);
        chk("inv_27", ram[27], 228);
        chk("inv_28", ram[28], 227);
        chk("inv_35", ram[35], 220);
        chk("inv_36", ram[36], 219);
        send(12);
        do_write(1'b0);
`endif

        repeat (3) begin
            for (int k = 0; k < N; k++) rom[k] = int'($urandom_range(0, 255));
            do_reset(1'b0);
            repeat (40) send(int'($urandom_range(1, 15)));
            do_write(1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
